exe_input_packer: RTL
=====================

EXE_INPUT_PACKER -- requirements
Module: exe_input_packer

Interface
REQ-001 The block SHALL have parameter NI, default 8, meaning the number of 32-bit lanes per vector issued to the downstream 8x8 adder tree.
REQ-002 The block SHALL have parameter CW, default 16, meaning the width of the issued-vector counter.
REQ-003 clk  in  1  single clock; all state is updated on the rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_data  in  32  FP32 word from the upstream memory or product stream.
REQ-006 in_valid  in  1  in_data is valid.
REQ-007 in_last  in  1  marks the final word of a short vector; qualified by in_valid.
REQ-008 in_ready  out  1  the block accepts in_data this cycle.
REQ-009 inputs  out  NI*32  packed vector to the adder tree; lane k occupies bits [32k+31:32k].
REQ-010 ExE_start  out  1  one-cycle issue pulse to the adder tree.
REQ-011 ExE_finish  in  1  one-cycle completion pulse from the adder tree.
REQ-012 busy  out  1  any bank is filling, full or in flight.
REQ-013 vec_count  out  CW  number of vectors issued since reset; wraps modulo 2^CW.
REQ-014 err_spurious  out  1  sticky flag: ExE_finish arrived while no vector was in flight.

Function
REQ-015 A word SHALL be accepted exactly when in_valid and in_ready are both high.
REQ-016 The fill bank SHALL write each accepted word into lane lane_idx, then increment lane_idx (0..NI-1).
REQ-017 The fill bank SHALL become FULL on acceptance of lane NI-1, or on acceptance of a word with in_last high; lane_idx then returns to 0.
REQ-018 On in_last at lane j<NI-1, lanes j+1..NI-1 SHALL be written 32'h0000_0000 (+0.0) in the same cycle.
REQ-019 Each bank SHALL have exactly one state out of EMPTY, FILLING, FULL and INFLIGHT, with these transitions only:
- EMPTY->FILLING on the first accepted word;
- FILLING->FULL per REQ-017;
- FULL->INFLIGHT on issue;
- INFLIGHT->EMPTY on ExE_finish.
REQ-020 Issue SHALL occur in the cycle after a bank becomes FULL, provided no bank is INFLIGHT; the issue SHALL drive ExE_start high for exactly one cycle and increment vec_count.
REQ-021 The inputs bus SHALL show the INFLIGHT bank and SHALL stay stable from the ExE_start cycle through the ExE_finish cycle, because the tree samples after an internal start delay.
REQ-022 At most one vector SHALL be in flight at a time.
REQ-023 ExE_finish and a bank becoming FULL in the same cycle SHALL lead to ExE_start in the next cycle.
REQ-024 ExE_finish SHALL never coincide with ExE_start for the same bank.
REQ-025 in_ready SHALL be low whenever no bank is EMPTY or FILLING.
REQ-026 ExE_finish with no INFLIGHT bank SHALL be ignored for all state and SHALL set err_spurious.
REQ-027 in_last at lane NI-1 SHALL behave as a normal full vector with no padding.

Reset
REQ-028 While rst_n is low, the following SHALL hold immediately, independent of clk:
- all banks EMPTY, lane_idx=0;
- inputs=0, ExE_start=0, in_ready=0, busy=0;
- vec_count=0, err_spurious=0.
REQ-029 in_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-030 Reset during FILLING or INFLIGHT SHALL discard the data; a later ExE_finish from the old vector SHALL set err_spurious.

Configuration
REQ-031 With EXE_PACKER_DBUF_EN defined, the block SHALL have two banks: one bank fills while the other is INFLIGHT, and the banks alternate fill and issue roles.
REQ-032 With EXE_PACKER_DBUF_EN undefined, the block SHALL have one bank, and in_ready SHALL be low from FULL until ExE_finish.

Structure
REQ-033 A shared package exe_pkg SHALL hold the bank-state enum, FP32_ZERO=32'h0, and the default NI.
REQ-034 One sub-module, exe_packer_bank, SHALL hold one bank's NI-lane register file, lane write and zero-pad logic; the top SHALL instantiate one bank or two according to EXE_PACKER_DBUF_EN.

Verification
REQ-035 Stream 8 words 1.0..8.0 with in_valid held high -> ExE_start one cycle after the 8th accept, inputs lane0=32'h3F80_0000, lane7=32'h4100_0000, vec_count=1.
REQ-036 Stream 3 words with in_last on the 3rd -> lanes 3..7 = 0, exactly one ExE_start.
REQ-037 Stream 16 words with ExE_finish 12 cycles after each start: with DBUF, in_ready never drops during the second fill; without DBUF, in_ready is low from 8th accept to finish; 2 starts total.
REQ-038 Pulse ExE_finish at idle -> err_spurious=1 and sticky, no ExE_start.
REQ-039 Assert rst_n low after the 5th word, release, then send 8 words -> a single vector containing only the new words, vec_count=1.
REQ-040 Issue 2^CW+1 vectors with CW=4 -> vec_count wraps to 1.

Source files
------------

// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared types and constants for the adder-tree input packer
package exe_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_INFLIGHT = 2'd3
    } bank_state_e;

    localparam logic [31:0] FP32_ZERO  = 32'h0000_0000;
    localparam int          NI_DEFAULT = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/exe_packer_bank.sv
// rtl/exe_packer_bank.sv - one NI-lane vector bank: lane fill, zero pad and bank state
module exe_packer_bank
    import exe_pkg::*;
#(
    parameter int NI = NI_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic             last_i,
    input  logic [31:0]      data_i,
    input  logic             issue_i,
    input  logic             finish_i,
    output logic [1:0]       state_o,
    output logic             done_o,
    output logic [NI*32-1:0] lanes_o
);

    localparam int LW = idx_width(NI);

    bank_state_e   state_q;
    logic [LW-1:0] lane_idx_q;
    logic [31:0]   lane_q [NI];
    logic          can_fill;

    assign can_fill = (state_q == BANK_EMPTY) || (state_q == BANK_FILLING);
    assign done_o   = wr_en_i && can_fill && (last_i || (lane_idx_q == LW'(NI - 1)));
    assign state_o  = state_q;

    always_comb begin
        lanes_o = '0;
        for (int k = 0; k < NI; k++) begin
            lanes_o[k*32 +: 32] = lane_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BANK_EMPTY;
            lane_idx_q <= '0;
            for (int k = 0; k < NI; k++) begin
                lane_q[k] <= FP32_ZERO;
            end
        end else begin
            case (state_q)
                BANK_EMPTY, BANK_FILLING: begin
                    if (wr_en_i) begin
                        // a short vector pads every lane above the last written one with +0.0
                        for (int k = 0; k < NI; k++) begin
                            if (k == int'(lane_idx_q)) begin
                                lane_q[k] <= data_i;
                            end else if (last_i && (k > int'(lane_idx_q))) begin
                                lane_q[k] <= FP32_ZERO;
                            end
                        end
                        if (done_o) begin
                            state_q    <= BANK_FULL;
                            lane_idx_q <= '0;
                        end else begin
                            state_q    <= BANK_FILLING;
                            lane_idx_q <= lane_idx_q + LW'(1);
                        end
                    end
                end
                BANK_FULL: begin
                    if (issue_i) begin
                        state_q <= BANK_INFLIGHT;
                    end
                end
                BANK_INFLIGHT: begin
                    if (finish_i) begin
                        state_q <= BANK_EMPTY;
                    end
                end
                default: state_q <= BANK_EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/exe_input_packer.sv
// rtl/exe_input_packer.sv - packs a 32-bit word stream into NI-lane vectors for the adder tree
// EXE_PACKER_DBUF_EN selects two alternating banks instead of one.
module exe_input_packer
    import exe_pkg::*;
#(
    parameter int NI = NI_DEFAULT,
    parameter int CW = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [NI*32-1:0] inputs,
    output logic             ExE_start,
    input  logic             ExE_finish,
    output logic             busy,
    output logic [CW-1:0]    vec_count,
    output logic             err_spurious
);

`ifdef EXE_PACKER_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic             ready_en_q;
    logic             fill_sel_q;
    logic [CW-1:0]    vec_count_q;
    logic             err_q;
    logic             accept;
    logic             fill_done;
    logic             any_inflight;
    logic             issue;
    logic [NB-1:0]    is_fill;
    logic [NB-1:0]    bank_wr;
    logic [NB-1:0]    bank_done;
    logic [NB-1:0]    bank_issue;
    logic [NB-1:0]    bank_empty;
    logic [NB-1:0]    bank_filling;
    logic [NB-1:0]    bank_full;
    logic [NB-1:0]    bank_inflight;
    logic [1:0]       bank_state [NB];
    logic [NI*32-1:0] bank_lanes [NB];

    for (genvar g = 0; g < NB; g++) begin : g_bank
        assign is_fill[g]       = (fill_sel_q == 1'(g));
        assign bank_wr[g]       = accept && is_fill[g];
        assign bank_empty[g]    = (bank_state[g] == BANK_EMPTY);
        assign bank_filling[g]  = (bank_state[g] == BANK_FILLING);
        assign bank_full[g]     = (bank_state[g] == BANK_FULL);
        assign bank_inflight[g] = (bank_state[g] == BANK_INFLIGHT);

        exe_packer_bank #(.NI(NI)) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_en_i  (bank_wr[g]),
            .last_i   (in_last),
            .data_i   (in_data),
            .issue_i  (bank_issue[g]),
            .finish_i (ExE_finish),
            .state_o  (bank_state[g]),
            .done_o   (bank_done[g]),
            .lanes_o  (bank_lanes[g])
        );
    end

`ifdef EXE_PACKER_DBUF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_sel_q <= 1'b0;
        end else if (fill_done) begin
            fill_sel_q <= ~fill_sel_q;
        end
    end
`else
    assign fill_sel_q = 1'b0;
`endif

    assign any_inflight = |bank_inflight;
    assign fill_done    = |bank_done;
    assign in_ready     = ready_en_q && (|(is_fill & (bank_empty | bank_filling)));
    assign accept       = in_valid && in_ready;
    assign issue        = |bank_issue;
    assign busy         = |(~bank_empty);
    assign ExE_start    = issue;
    assign vec_count    = vec_count_q;
    assign err_spurious = err_q;

    // a FULL bank issues only while the tree is idle; a finish this cycle frees it for next cycle
    always_comb begin
        logic taken;
        taken      = 1'b0;
        bank_issue = '0;
        for (int b = 0; b < NB; b++) begin
            if (bank_full[b] && !any_inflight && !taken) begin
                bank_issue[b] = 1'b1;
                taken         = 1'b1;
            end
        end
    end

    // the tree reads its operands late, so the issued bank stays on the bus until finish
    always_comb begin
        inputs = '0;
        for (int b = 0; b < NB; b++) begin
            if (bank_issue[b] || bank_inflight[b]) begin
                inputs = bank_lanes[b];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q  <= 1'b0;
            vec_count_q <= '0;
            err_q       <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            if (issue) begin
                vec_count_q <= vec_count_q + CW'(1);
            end
            if (ExE_finish && !any_inflight) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule
